// File: rtl/linear_regr_pkg.sv
// Shared types and width derivations for the streaming least-squares line fitter.
package linear_regr_pkg;

    typedef enum logic [2:0] {ACCUM, PREP, DIV_S, DIV_I, DONE} state_t;

    function automatic int sum_w(input int s_w, input int n_w);
        return s_w + n_w;
    endfunction

    function automatic int sxx_w(input int x_w, input int n_w);
        return 2 * x_w + n_w;
    endfunction

    function automatic int sxy_w(input int x_w, input int y_w, input int n_w);
        return x_w + y_w + n_w;
    endfunction

    // Signed width that holds n*Sxx, Sy*Sxx and the differences without loss.
    function automatic int prod_w(input int x_w, input int y_w, input int n_w);
        return 2 * x_w + y_w + 2 * n_w + 2;
    endfunction

    function automatic int div_w(input int p_w, input int frac_bits);
        return p_w + frac_bits;
    endfunction

    function automatic logic [63:0] sat_mag(input int out_w);
        return (64'd1 << (out_w - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/linear_regr_if.sv
// Sample/command inputs and fit results of the line fitter.
interface linear_regr_if #(
    parameter int X_W   = 11,
    parameter int Y_W   = 10,
    parameter int N_W   = 21,
    parameter int OUT_W = 24
);
    logic [X_W-1:0]          x_in;
    logic [Y_W-1:0]          y_in;
    logic                    valid_in;
    logic                    tabulate_in;
    logic                    clear_in;
    logic signed [OUT_W-1:0] slope_out;
    logic signed [OUT_W-1:0] intercept_out;
    logic [N_W-1:0]          count_out;
    logic                    valid_out;
    logic                    error_out;
    logic                    sat_out;
    logic                    busy_out;
    logic                    drop_out;

    modport master (
        output x_in, y_in, valid_in, tabulate_in, clear_in,
        input  slope_out, intercept_out, count_out, valid_out,
        input  error_out, sat_out, busy_out, drop_out
    );

    modport slave (
        input  x_in, y_in, valid_in, tabulate_in, clear_in,
        output slope_out, intercept_out, count_out, valid_out,
        output error_out, sat_out, busy_out, drop_out
    );
endinterface

// File: rtl/seq_udiv.sv
// Unsigned restoring divider, one quotient bit per cycle.
// Latency: done pulses exactly DW cycles after the start cycle.
// Backpressure: none; start restarts the divider even mid-operation.
module seq_udiv #(
    parameter int DW = 84
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic          done,
    output logic [DW-1:0] quot
);
    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0] rem, q, src_r, src_q, r_n, q_n;
    logic [DW:0]   t;
    logic          ge;
    logic [CW-1:0] cnt;

    // The start cycle already performs the first step on the fresh operands.
    always_comb begin
        src_r = start ? '0 : rem;
        src_q = start ? dividend : q;
        t     = {src_r, src_q[DW-1]};
        ge    = (t >= {1'b0, divisor});
        r_n   = ge ? DW'(t - {1'b0, divisor}) : t[DW-1:0];
        q_n   = {src_q[DW-2:0], ge};
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rem  <= '0;
            q    <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (start) begin
            rem  <= r_n;
            q    <= q_n;
            cnt  <= CW'(DW - 1);
            done <= 1'b0;
        end else if (cnt != '0) begin
            rem  <= r_n;
            q    <= q_n;
            cnt  <= cnt - 1'b1;
            done <= (cnt == CW'(1));
        end else begin
            done <= 1'b0;
        end
    end

    assign quot = q;
endmodule

// File: rtl/linear_regr_fx.sv
// Streaming least-squares line fitter with signed fixed-point slope/intercept.
// Latency: valid_out 2*DW+3 cycles from the tabulate cycle, 2 cycles for degenerate fits.
// Backpressure: none; samples arriving while busy are discarded and flagged on drop_out.
module linear_regr_fx
    import linear_regr_pkg::*;
#(
    parameter int X_W       = 11,
    parameter int Y_W       = 10,
    parameter int N_W       = 21,
    parameter int FRAC_BITS = 8,
    parameter int OUT_W     = 24
) (
    input logic          clk_in,
    input logic          rst_in,
    linear_regr_if.slave bus
);
    localparam int SX_W  = sum_w(X_W, N_W);
    localparam int SY_W  = sum_w(Y_W, N_W);
    localparam int SXX_W = sxx_w(X_W, N_W);
    localparam int SXY_W = sxy_w(X_W, Y_W, N_W);
    localparam int P     = prod_w(X_W, Y_W, N_W);
    localparam int DW    = div_w(P, FRAC_BITS);
    localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(sat_mag(OUT_W));

    state_t state, nxt;

    logic [N_W-1:0]   n;
    logic [SX_W-1:0]  sx;
    logic [SY_W-1:0]  sy;
    logic [SXX_W-1:0] sxx;
    logic [SXY_W-1:0] sxy;
    logic             ovf;

    logic [P-1:0]     d_c, ns_c, ni_c, mag_d, mag_s, mag_i;
    logic             sign_s, sign_i, degen, go_q;
    logic             div_start, div_done, q_sat, q_neg, ssat_q;
    logic [DW-1:0]    dividend, div_q;
    logic [OUT_W-1:0] q_mag, q_val, slope_q;

    logic [OUT_W-1:0] slope_o, icpt_o;
    logic [N_W-1:0]   count_o;
    logic             valid_o, err_o, sat_o, drop_o;

    function automatic logic [P-1:0] abs_p(input logic [P-1:0] v);
        return v[P-1] ? (~v + 1'b1) : v;
    endfunction

    // Exact values fit in P signed bits, so modular P-bit arithmetic suffices.
    assign d_c   = P'(n) * P'(sxx) - P'(sx) * P'(sx);
    assign ns_c  = P'(n) * P'(sxy) - P'(sx) * P'(sy);
    assign ni_c  = P'(sy) * P'(sxx) - P'(sx) * P'(sxy);
    assign degen = (n < N_W'(2)) || (d_c == '0) || ovf;

    always_comb begin
        nxt       = state;
        div_start = go_q | ((state == DIV_S) && div_done);
        dividend  = div_done ? {mag_i, {FRAC_BITS{1'b0}}} : {mag_s, {FRAC_BITS{1'b0}}};
        unique case (state)
            ACCUM:   if (bus.tabulate_in) nxt = PREP;
            PREP:    nxt = degen ? DONE : DIV_S;
            DIV_S:   if (div_done) nxt = DIV_I;
            DIV_I:   if (div_done) nxt = DONE;
            DONE:    nxt = ACCUM;
            default: nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= ACCUM;
        else         state <= nxt;
    end

    seq_udiv #(.DW(DW)) u_div (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .start    (div_start),
        .dividend (dividend),
        .divisor  (DW'(mag_d)),
        .done     (div_done),
        .quot     (div_q)
    );

    always_comb begin
        q_sat = (div_q > DW'(MAX_OUT));
        q_neg = (state == DIV_S) ? sign_s : sign_i;
        q_mag = q_sat ? MAX_OUT : div_q[OUT_W-1:0];
        q_val = q_neg ? (~q_mag + 1'b1) : q_mag;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            n <= '0; sx <= '0; sy <= '0; sxx <= '0; sxy <= '0; ovf <= 1'b0;
            mag_d <= '0; mag_s <= '0; mag_i <= '0; sign_s <= 1'b0; sign_i <= 1'b0;
            go_q <= 1'b0; slope_q <= '0; ssat_q <= 1'b0;
            slope_o <= '0; icpt_o <= '0; count_o <= '0;
            valid_o <= 1'b0; err_o <= 1'b0; sat_o <= 1'b0; drop_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            go_q    <= 1'b0;
            drop_o  <= bus.valid_in && (state != ACCUM);
            case (state)
                ACCUM: begin
                    if (bus.clear_in) begin
                        n <= '0; sx <= '0; sy <= '0; sxx <= '0; sxy <= '0; ovf <= 1'b0;
                    end else if (bus.valid_in) begin
                        if (n == {N_W{1'b1}}) begin
                            ovf <= 1'b1;
                        end else begin
                            n   <= n + 1'b1;
                            sx  <= sx + SX_W'(bus.x_in);
                            sy  <= sy + SY_W'(bus.y_in);
                            sxx <= sxx + SXX_W'(bus.x_in) * SXX_W'(bus.x_in);
                            sxy <= sxy + SXY_W'(bus.x_in) * SXY_W'(bus.y_in);
                        end
                    end
                end
                PREP: begin
                    mag_d   <= abs_p(d_c);
                    mag_s   <= abs_p(ns_c);
                    mag_i   <= abs_p(ni_c);
                    sign_s  <= ns_c[P-1] ^ d_c[P-1];
                    sign_i  <= ni_c[P-1] ^ d_c[P-1];
                    count_o <= n;
                    go_q    <= !degen;
                    if (degen) begin
                        slope_o <= '0; icpt_o <= '0;
                        err_o <= 1'b1; sat_o <= 1'b0; valid_o <= 1'b1;
                    end
                end
                DIV_S: if (div_done) begin
                    slope_q <= q_val;
                    ssat_q  <= q_sat;
                end
                DIV_I: if (div_done) begin
                    slope_o <= slope_q;
                    icpt_o  <= q_val;
                    sat_o   <= ssat_q | q_sat;
                    err_o   <= 1'b0;
                    valid_o <= 1'b1;
                end
                DONE: begin
                    n <= '0; sx <= '0; sy <= '0; sxx <= '0; sxy <= '0; ovf <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.slope_out     = slope_o;
    assign bus.intercept_out = icpt_o;
    assign bus.count_out     = count_o;
    assign bus.valid_out     = valid_o;
    assign bus.error_out     = err_o;
    assign bus.sat_out       = sat_o;
    assign bus.busy_out      = (state != ACCUM);
    assign bus.drop_out      = drop_o;
endmodule

// File: tb/tb_linear_regr_fx.sv
// Bench for linear_regr_fx: a 24-bit and a 12-bit output instance share one sample stream;
// an arithmetic model predicts each fit into per-instance scoreboards.
module tb_linear_regr_fx;
    import linear_regr_pkg::*;

    localparam int DW      = div_w(prod_w(11, 10, 21), 8);
    localparam int LAT     = 2 * DW + 3;
    localparam longint MAXA = 64'd8388607;
    localparam longint MAXB = 64'd2047;

    typedef struct {
        longint slope;
        longint icpt;
        longint cnt;
        longint err;
        longint sat;
        longint lat;
        longint tc;
    } exp_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    logic [10:0] xv  = '0;
    logic [9:0]  yv  = '0;
    logic        vld = 1'b0;
    logic        tab = 1'b0;
    logic        clr = 1'b0;

    linear_regr_if #(.X_W(11), .Y_W(10), .N_W(21), .OUT_W(24)) bus_a ();
    linear_regr_if #(.X_W(11), .Y_W(10), .N_W(21), .OUT_W(12)) bus_b ();

    assign bus_a.x_in = xv;  assign bus_a.y_in = yv;  assign bus_a.valid_in = vld;
    assign bus_a.tabulate_in = tab;  assign bus_a.clear_in = clr;
    assign bus_b.x_in = xv;  assign bus_b.y_in = yv;  assign bus_b.valid_in = vld;
    assign bus_b.tabulate_in = tab;  assign bus_b.clear_in = clr;

    linear_regr_fx #(.X_W(11), .Y_W(10), .N_W(21), .FRAC_BITS(8), .OUT_W(24)) u_dut (
        .clk_in (clk_in), .rst_in (rst_in), .bus (bus_a));
    linear_regr_fx #(.X_W(11), .Y_W(10), .N_W(21), .FRAC_BITS(8), .OUT_W(12)) u_sat (
        .clk_in (clk_in), .rst_in (rst_in), .bus (bus_b));

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    longint mn = 0, msx = 0, msy = 0, msxx = 0, msxy = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    function automatic exp_t predict(input longint maxm, input longint tc);
        exp_t   e;
        longint d, ns, ni, ms, mi;
        d  = mn * msxx - msx * msx;
        ns = mn * msxy - msx * msy;
        ni = msy * msxx - msx * msxy;
        e.cnt = mn;
        e.tc  = tc;
        if (mn < 2 || d == 0) begin
            e.slope = 0; e.icpt = 0; e.err = 1; e.sat = 0; e.lat = 2;
        end else begin
            ms = ((ns < 0 ? -ns : ns) * 256) / (d < 0 ? -d : d);
            mi = ((ni < 0 ? -ni : ni) * 256) / (d < 0 ? -d : d);
            e.sat = (ms > maxm || mi > maxm) ? 1 : 0;
            if (ms > maxm) ms = maxm;
            if (mi > maxm) mi = maxm;
            e.slope = ((ns < 0) != (d < 0)) ? -ms : ms;
            e.icpt  = ((ni < 0) != (d < 0)) ? -mi : mi;
            e.err = 0; e.lat = LAT;
        end
        return e;
    endfunction

    task automatic cmp_res(input string who, input exp_t e, input longint s, input longint i,
                           input longint c, input longint er, input longint sa);
        chk({who, "_slope"}, s, e.slope);
        chk({who, "_intercept"}, i, e.icpt);
        chk({who, "_count"}, c, e.cnt);
        chk({who, "_error"}, er, e.err);
        chk({who, "_sat"}, sa, e.sat);
        chk({who, "_latency"}, longint'(cyc) - e.tc, e.lat);
    endtask

    always @(negedge clk_in) begin
        if (rst_in && bus_a.valid_out) begin
            if (qa.size() == 0) chk("a_unexpected_valid", 1, 0);
            else begin
                ea = qa.pop_front();
                cmp_res("a", ea, longint'(bus_a.slope_out), longint'(bus_a.intercept_out),
                        longint'(bus_a.count_out), longint'(bus_a.error_out), longint'(bus_a.sat_out));
            end
        end
        if (rst_in && bus_b.valid_out) begin
            if (qb.size() == 0) chk("b_unexpected_valid", 1, 0);
            else begin
                eb = qb.pop_front();
                cmp_res("b", eb, longint'(bus_b.slope_out), longint'(bus_b.intercept_out),
                        longint'(bus_b.count_out), longint'(bus_b.error_out), longint'(bus_b.sat_out));
            end
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic model_add(input int x, input int y);
        mn++; msx += x; msy += y; msxx += x * x; msxy += x * y;
    endtask

    task automatic model_clear();
        mn = 0; msx = 0; msy = 0; msxx = 0; msxy = 0;
    endtask

    task automatic push_fit();
        qa.push_back(predict(MAXA, longint'(cyc)));
        qb.push_back(predict(MAXB, longint'(cyc)));
        model_clear();
    endtask

    task automatic send(input int x, input int y);
        xv = 11'(x); yv = 10'(y); vld = 1'b1;
        model_add(x, y);
        step();
        vld = 1'b0;
    endtask

    task automatic send_tab(input int x, input int y);
        xv = 11'(x); yv = 10'(y); vld = 1'b1; tab = 1'b1;
        model_add(x, y);
        push_fit();
        step();
        vld = 1'b0; tab = 1'b0;
    endtask

    task automatic tabulate();
        tab = 1'b1;
        push_fit();
        step();
        tab = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((qa.size() != 0 || qb.size() != 0) && k < 2 * LAT) begin
            step();
            k++;
        end
        chk("result_wait_timeout", longint'(qa.size() + qb.size()), 0);
        qa.delete();
        qb.delete();
        step();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_a_busy"}, longint'(bus_a.busy_out), 0);
        chk({tag, "_a_slope"}, longint'(bus_a.slope_out), 0);
        chk({tag, "_a_intercept"}, longint'(bus_a.intercept_out), 0);
        chk({tag, "_a_valid"}, longint'(bus_a.valid_out), 0);
        chk({tag, "_a_error"}, longint'(bus_a.error_out), 0);
        chk({tag, "_b_busy"}, longint'(bus_b.busy_out), 0);
        chk({tag, "_b_slope"}, longint'(bus_b.slope_out), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk_in);
        #1;
        chk_idle_outputs("reset");
        chk("reset_count", longint'(bus_a.count_out), 0);
        rst_in = 1'b1;
        step();

        send(0, 1); send(1, 3); send(2, 5); tabulate(); wait_idle();
        send(0, 10); send(2, 6); send(4, 2); tabulate(); wait_idle();
        send(0, 0); send(3, 1); tabulate(); wait_idle();
        send(5, 1); send(5, 2); tabulate(); wait_idle();
        send(7, 3); tabulate(); wait_idle();
        send(0, 0); send(1, 1000); tabulate(); wait_idle();
        send(0, 1); send(1, 3); send_tab(2, 5); wait_idle();

        // Sample injected mid-division must be dropped and leave the fit untouched.
        send(0, 1); send(1, 3); send(2, 5); tabulate();
        repeat (5) step();
        chk("busy_in_div", longint'(bus_a.busy_out), 1);
        xv = 11'd9; yv = 10'd9; vld = 1'b1;
        step();
        vld = 1'b0;
        chk("drop_pulse_a", longint'(bus_a.drop_out), 1);
        chk("drop_pulse_b", longint'(bus_b.drop_out), 1);
        step();
        chk("drop_one_cycle", longint'(bus_a.drop_out), 0);
        wait_idle();

        send(1, 1); send(2, 2);
        clr = 1'b1; model_clear(); step(); clr = 1'b0;
        tabulate(); wait_idle();

        send(0, 1); send(1, 3); send(2, 5); tabulate();
        repeat (DW + 20) step();
        chk("div_i_busy_before_reset", longint'(bus_a.busy_out), 1);
        rst_in = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        chk_idle_outputs("midreset");
        step();
        rst_in = 1'b1;
        step();
        send(0, 10); send(2, 6); send(4, 2); tabulate(); wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
